// File: rtl/iic_seq.sv
// Transaction sequencer for iic_core: expands one register read/write request
// into the ordered START/address/register/data byte ops with busy handshaking.
module iic_seq #(
    parameter logic [15:0] TIMEOUT = 16'd4095,
    parameter int          LEN_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic             req_rw,
    input  logic [6:0]       dev_addr,
    input  logic [7:0]       reg_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [7:0]       rdata,
    output logic             rdata_valid,
    output logic             busy_o,
    output logic             done,
    output logic             err,
    output logic             core_start,
    output logic             core_stop,
    output logic             core_rw,
    output logic [7:0]       core_din,
    input  logic [7:0]       core_dout,
    input  logic             core_busy,
    input  logic             core_sending
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_AB_ISSUE, S_AB_WAIT, S_END
    } state_t;

    typedef enum logic [1:0] {P_ADDR_W, P_REG, P_ADDR_R, P_DATA} phase_t;

    state_t           state;
    phase_t           phase;
    logic             rw_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bcnt;
    logic [15:0]      tcnt;
    logic             tmo;

    // The core's sending flag is status only; sequencing relies on busy alone.
    logic unused_sending;
    assign unused_sending = core_sending;

    assign tmo = (tcnt == TIMEOUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            phase       <= P_ADDR_W;
            rw_q        <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            len_q       <= '0;
            bcnt        <= '0;
            tcnt        <= '0;
            wdata_ready <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            busy_o      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            core_start  <= 1'b0;
            core_stop   <= 1'b0;
            core_rw     <= 1'b0;
            core_din    <= '0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;
            case (state)
                S_IDLE: if (req) begin
                    rw_q       <= req_rw;
                    dev_q      <= dev_addr;
                    reg_q      <= reg_addr;
                    len_q      <= len;
                    busy_o     <= 1'b1;
                    phase      <= P_ADDR_W;
                    core_start <= 1'b1;
                    core_stop  <= 1'b0;
                    core_rw    <= 1'b0;
                    core_din   <= {dev_addr, 1'b0};
                    tcnt       <= '0;
                    state      <= S_ISSUE;
                end

                // Waiting on the requester is unbounded: no timeout here.
                S_FETCH: if (wdata_valid) begin
                    wdata_ready <= 1'b0;
                    core_din    <= wdata;
                    core_start  <= 1'b0;
                    core_stop   <= (bcnt == '0);
                    core_rw     <= 1'b0;
                    tcnt        <= '0;
                    state       <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (core_busy) begin
                        core_start <= 1'b0;
                        core_stop  <= 1'b0;
                        tcnt       <= '0;
                        state      <= S_WAIT;
                    end else if (tmo) begin
                        core_start <= 1'b0;
                        core_stop  <= 1'b1;
                        core_rw    <= 1'b0;
                        core_din   <= 8'hFF;
                        tcnt       <= '0;
                        state      <= S_AB_ISSUE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end

                S_WAIT: begin
                    if (!core_busy) begin
                        tcnt <= '0;
                        case (phase)
                            P_ADDR_W: begin
                                phase    <= P_REG;
                                core_din <= reg_q;
                                state    <= S_ISSUE;
                            end
                            P_REG: begin
                                if (rw_q) begin
                                    phase      <= P_ADDR_R;
                                    core_start <= 1'b1;
                                    core_din   <= {dev_q, 1'b1};
                                    state      <= S_ISSUE;
                                end else begin
                                    phase       <= P_DATA;
                                    bcnt        <= len_q;
                                    wdata_ready <= 1'b1;
                                    state       <= S_FETCH;
                                end
                            end
                            P_ADDR_R: begin
                                phase     <= P_DATA;
                                bcnt      <= len_q;
                                core_rw   <= 1'b1;
                                core_din  <= 8'h00;
                                core_stop <= (len_q == '0);
                                state     <= S_ISSUE;
                            end
                            P_DATA: begin
                                if (core_rw) begin
                                    rdata       <= core_dout;
                                    rdata_valid <= 1'b1;
                                end
                                // bcnt==0 was the stop-carrying byte; never decrement past it.
                                if (bcnt == '0) begin
                                    done     <= 1'b1;
                                    busy_o   <= 1'b0;
                                    core_rw  <= 1'b0;
                                    core_din <= '0;
                                    state    <= S_END;
                                end else begin
                                    bcnt <= bcnt - LEN_W'(1);
                                    if (rw_q) begin
                                        core_stop <= (bcnt == LEN_W'(1));
                                        state     <= S_ISSUE;
                                    end else begin
                                        wdata_ready <= 1'b1;
                                        state       <= S_FETCH;
                                    end
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else if (tmo) begin
                        core_start <= 1'b0;
                        core_stop  <= 1'b1;
                        core_rw    <= 1'b0;
                        core_din   <= 8'hFF;
                        tcnt       <= '0;
                        state      <= S_AB_ISSUE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end

                S_AB_ISSUE: begin
                    if (core_busy) begin
                        core_stop <= 1'b0;
                        tcnt      <= '0;
                        state     <= S_AB_WAIT;
                    end else if (tmo) begin
                        err       <= 1'b1;
                        busy_o    <= 1'b0;
                        core_stop <= 1'b0;
                        core_din  <= '0;
                        state     <= S_END;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end

                S_AB_WAIT: begin
                    if (!core_busy || tmo) begin
                        err      <= 1'b1;
                        busy_o   <= 1'b0;
                        core_din <= '0;
                        state    <= S_END;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end

                // One dead cycle so a req coinciding with done/err is not taken.
                S_END: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_seq.sv
// Bench for iic_seq: a behavioural iic_core answers byte ops; ops and read
// bytes are scoreboarded against expectations queued as stimulus is driven.
module tb_iic_seq;

    localparam logic [15:0] TMO = 16'd40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req, req_rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [3:0] len;
    logic [7:0] wdata;
    logic       wdata_valid, wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid, busy_o, done, err;
    logic       core_start, core_stop, core_rw;
    logic [7:0] core_din, core_dout;
    logic       core_busy, core_sending;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int op_cnt = 0;
    int last_op_cyc = 0;
    int prev_op_cyc = 0;
    int stall_rdy = 0;
    bit hang_mode = 1'b0;

    logic [10:0] exp_ops[$];
    logic [7:0]  rd_src[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  wq[$];
    logic [23:0] outs;

    assign outs = {wdata_ready, rdata, rdata_valid, busy_o, done, err,
                   core_start, core_stop, core_rw, core_din};

    iic_seq #(.TIMEOUT(TMO), .LEN_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_rw(req_rw),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .len(len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy_o(busy_o),
        .done(done), .err(err), .core_start(core_start), .core_stop(core_stop),
        .core_rw(core_rw), .core_din(core_din), .core_dout(core_dout),
        .core_busy(core_busy), .core_sending(core_sending)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Read ops carry no meaningful din.
    function automatic logic [10:0] norm(input logic [10:0] o);
        return o[8] ? {o[10:8], 8'h00} : o;
    endfunction

    // Behavioural core: takes a pending op, raises busy after 0..2 cycles,
    // holds it 1..3 cycles. In hang_mode it ignores ops without start/stop.
    initial begin
        int m_st, m_cnt;
        bit m_rw;
        logic [10:0] m_op, m_exp;
        m_st = 0; m_cnt = 0; m_rw = 1'b0;
        core_busy = 1'b0; core_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_st = 0; core_busy = 1'b0;
            end else begin
                case (m_st)
                    0: if (busy_o && !wdata_ready && (!hang_mode || core_start || core_stop)) begin
                        m_op = {core_start, core_stop, core_rw, core_din};
                        op_cnt++;
                        prev_op_cyc = last_op_cyc;
                        last_op_cyc = cyc;
                        total++;
                        if (exp_ops.size() == 0) begin
                            bad++;
                            $display("FAIL op_seq: got unexpected op %h", m_op);
                        end else begin
                            m_exp = exp_ops.pop_front();
                            if (norm(m_op) !== norm(m_exp)) begin
                                bad++;
                                $display("FAIL op_seq: got %h want %h", norm(m_op), norm(m_exp));
                            end
                        end
                        m_rw  = core_rw;
                        m_cnt = $urandom_range(0, 2);
                        m_st  = 1;
                    end
                    1: if (m_cnt == 0) begin
                        core_busy = 1'b1;
                        m_cnt = $urandom_range(0, 2);
                        m_st = 2;
                    end else m_cnt--;
                    default: if (m_cnt == 0) begin
                        core_busy = 1'b0;
                        if (m_rw) core_dout = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
                        m_st = 0;
                    end else m_cnt--;
                endcase
            end
        end
    end

    // Pulse counters and read-data scoreboard.
    initial begin
        logic [7:0] r;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (rdata_valid) begin
                    total++;
                    if (exp_rd.size() == 0) begin
                        bad++;
                        $display("FAIL rdata: got unexpected byte %h", rdata);
                    end else begin
                        r = exp_rd.pop_front();
                        if (rdata !== r) begin
                            bad++;
                            $display("FAIL rdata: got %h want %h", rdata, r);
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                            input int nb, input int first);
        exp_ops.push_back({3'b100, dev, 1'b0});
        exp_ops.push_back({3'b000, ra});
        if (rw) exp_ops.push_back({3'b100, dev, 1'b1});
        for (int i = 0; i < nb; i++)
            exp_ops.push_back({1'b0, (i == nb - 1), rw, rw ? 8'h00 : wq[first + i]});
    endtask

    task automatic do_txn(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [3:0] ln, input int nbytes, input int stall_idx,
                          input int stall_n, input bit drive_req, input bit hold_req,
                          output bit to);
        bit to_f, to_w;
        to_f = 1'b0; to_w = 1'b0;
        if (drive_req) begin
            @(negedge clk);
            req_rw = rw; dev_addr = dev; reg_addr = ra; len = ln; req = 1'b1;
        end
        @(negedge clk);
        if (!hold_req) req = 1'b0;
        fork
            begin
                for (int i = 0; i < nbytes; i++) begin
                    if (i == stall_idx)
                        for (int s = 0; s < stall_n; s++) begin
                            if (s >= 15 && wdata_ready) stall_rdy++;
                            @(negedge clk);
                        end
                    wdata = wq[i]; wdata_valid = 1'b1;
                    for (int k = 0; k < 400 && !wdata_ready; k++) @(negedge clk);
                    if (!wdata_ready) to_f = 1'b1;
                    @(negedge clk);
                    wdata_valid = 1'b0;
                end
            end
            begin
                int kw;
                kw = 0;
                while (!done && !err && kw < 3000) begin @(negedge clk); kw++; end
                if (!done && !err) to_w = 1'b1;
            end
        join
        to = to_f | to_w;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (outs !== 24'h0) begin bad++; $display("FAIL reset_outputs: got %h want 000000", outs); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy_o, done, err} !== 3'b000) begin
            bad++; $display("FAIL idle_after_reset: got %b want 000", {busy_o, done, err});
        end
    endtask

    task automatic test_write();
        int d0, e0; bit to;
        d0 = done_cnt; e0 = err_cnt;
        wq = {8'hA5};
        push_exp(1'b0, 7'h50, 8'h10, 1, 0);
        do_txn(1'b0, 7'h50, 8'h10, 4'd0, 1, -1, 0, 1'b1, 1'b0, to);
        @(negedge clk);
        total++; if (to) begin bad++; $display("FAIL write_timeout: got timeout want done"); end
        total++; if (exp_ops.size() != 0) begin bad++; $display("FAIL write_ops: %0d ops missing want 0", exp_ops.size()); end
        total++; if (done_cnt - d0 != 1 || err_cnt != e0) begin
            bad++; $display("FAIL write_done: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_read();
        int d0, e0; bit to;
        d0 = done_cnt; e0 = err_cnt;
        rd_src = {8'h11, 8'h22, 8'h33};
        exp_rd = {8'h11, 8'h22, 8'h33};
        push_exp(1'b1, 7'h50, 8'h02, 3, 0);
        do_txn(1'b1, 7'h50, 8'h02, 4'd2, 0, -1, 0, 1'b1, 1'b0, to);
        @(negedge clk);
        total++; if (to) begin bad++; $display("FAIL read_timeout: got timeout want done"); end
        total++; if (exp_ops.size() != 0) begin bad++; $display("FAIL read_ops: %0d ops missing want 0", exp_ops.size()); end
        total++; if (exp_rd.size() != 0) begin bad++; $display("FAIL read_bytes: %0d bytes missing want 0", exp_rd.size()); end
        total++; if (done_cnt - d0 != 1 || err_cnt != e0) begin
            bad++; $display("FAIL read_done: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_stall();
        int d0, e0; bit to;
        d0 = done_cnt; e0 = err_cnt; stall_rdy = 0;
        wq = {8'h01, 8'h02, 8'h03, 8'h04};
        push_exp(1'b0, 7'h21, 8'h20, 4, 0);
        do_txn(1'b0, 7'h21, 8'h20, 4'd3, 4, 1, 50, 1'b1, 1'b0, to);
        @(negedge clk);
        total++; if (to) begin bad++; $display("FAIL stall_timeout: got timeout want done"); end
        total++; if (exp_ops.size() != 0) begin bad++; $display("FAIL stall_ops: %0d ops missing want 0", exp_ops.size()); end
        total++; if (stall_rdy != 35) begin bad++; $display("FAIL stall_ready: got %0d high cycles want 35", stall_rdy); end
        total++; if (done_cnt - d0 != 1 || err_cnt != e0) begin
            bad++; $display("FAIL stall_done: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        int d0, e0; bit to;
        d0 = done_cnt; e0 = err_cnt;
        hang_mode = 1'b1;
        exp_ops.push_back({3'b100, 7'h50, 1'b0});
        exp_ops.push_back({3'b010, 8'hFF});
        do_txn(1'b0, 7'h50, 8'h10, 4'd0, 0, -1, 0, 1'b1, 1'b0, to);
        @(negedge clk);
        hang_mode = 1'b0;
        total++; if (to) begin bad++; $display("FAIL abort_timeout: got no err/done want err"); end
        total++; if (exp_ops.size() != 0) begin bad++; $display("FAIL abort_ops: %0d ops missing want 0", exp_ops.size()); end
        total++; if (err_cnt - e0 != 1 || done_cnt != d0) begin
            bad++; $display("FAIL abort_err: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        total++; if (last_op_cyc - prev_op_cyc < int'(TMO)) begin
            bad++; $display("FAIL abort_delay: got %0d cycles want >= %0d", last_op_cyc - prev_op_cyc, TMO);
        end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy_o=%b want 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        int d0, e0, base, k; bit to;
        base = op_cnt;
        rd_src = {8'h5A, 8'h6B, 8'h7C};
        exp_ops.push_back({3'b100, 7'h2C, 1'b0});
        exp_ops.push_back({3'b000, 8'h07});
        exp_ops.push_back({3'b100, 7'h2C, 1'b1});
        exp_ops.push_back({3'b001, 8'h00});
        @(negedge clk);
        req_rw = 1'b1; dev_addr = 7'h2C; reg_addr = 8'h07; len = 4'd2; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        k = 0;
        while (op_cnt < base + 4 && k < 200) begin @(negedge clk); k++; end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL midrd_busy: got %b want 1", busy_o); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (outs !== 24'h0) begin bad++; $display("FAIL async_reset: got %h want 000000", outs); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rd_src = {};
        total++; if (exp_ops.size() != 0) begin bad++; $display("FAIL midrd_ops: %0d ops missing want 0", exp_ops.size()); end
        d0 = done_cnt; e0 = err_cnt;
        wq = {8'hC3};
        push_exp(1'b0, 7'h3A, 8'h44, 1, 0);
        do_txn(1'b0, 7'h3A, 8'h44, 4'd0, 1, -1, 0, 1'b1, 1'b0, to);
        @(negedge clk);
        total++; if (to || exp_ops.size() != 0) begin
            bad++; $display("FAIL post_reset_txn: got timeout=%b missing=%0d want 0 0", to, exp_ops.size());
        end
        total++; if (done_cnt - d0 != 1 || err_cnt != e0) begin
            bad++; $display("FAIL post_reset_done: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int d0, gap, k; bit to1, to2;
        d0 = done_cnt;
        wq = {8'h5C, 8'hD7};
        push_exp(1'b0, 7'h1B, 8'h33, 1, 0);
        push_exp(1'b0, 7'h1B, 8'h33, 1, 1);
        wq = {8'h5C};
        do_txn(1'b0, 7'h1B, 8'h33, 4'd0, 1, -1, 0, 1'b1, 1'b1, to1);
        gap = 0; k = 0;
        @(negedge clk);
        while (!busy_o && k < 20) begin gap++; @(negedge clk); k++; end
        total++; if (to1) begin bad++; $display("FAIL b2b_first: got timeout want done"); end
        total++; if (gap < 1 || busy_o !== 1'b1) begin
            bad++; $display("FAIL b2b_gap: got gap=%0d busy=%b want >=1 1", gap, busy_o);
        end
        wq = {8'hD7};
        do_txn(1'b0, 7'h1B, 8'h33, 4'd0, 1, -1, 0, 1'b0, 1'b0, to2);
        repeat (20) @(negedge clk);
        total++; if (to2 || exp_ops.size() != 0) begin
            bad++; $display("FAIL b2b_second: got timeout=%b missing=%0d want 0 0", to2, exp_ops.size());
        end
        total++; if (done_cnt - d0 != 2 || busy_o !== 1'b0) begin
            bad++; $display("FAIL b2b_count: got done=%0d busy=%b want 2 0", done_cnt - d0, busy_o);
        end
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; req_rw = 1'b0; dev_addr = '0; reg_addr = '0;
        len = '0; wdata = '0; wdata_valid = 1'b0; core_sending = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
